bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.

---
 rtl/bin_to_bcd_seq.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// Feeds the seven-segment decoder so the displays read decimal instead of hex.
// One input bit is consumed per cycle. Out-of-range values are shown as all-F digits.
`timescale 1ns/1ps

module bin_to_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  ovf
);

    localparam int unsigned MAXV  = 10**DIGITS - 1;
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam int          WRK_W = 4*DIGITS + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BIN_W-1:0]     shreg;
    logic [4*DIGITS-1:0]  scratch;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_pend;
    logic [WRK_W-1:0]     sh_work;

    assign bin_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, leave SHIFT on the last bit, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bin_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift the whole
    // {scratch, shreg} vector left so the next binary bit enters the units digit.
    // The bit shifted out of the top digit is dropped.
    always_comb begin
        sh_work = {scratch, shreg};
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_work[BIN_W + 4*i +: 4] >= 4'd5) begin
                sh_work[BIN_W + 4*i +: 4] = sh_work[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sh_work = sh_work << 1;
    end

    // Datapath: load on accept, shift while busy, publish the result on DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        shreg    <= bin_in;
                        scratch  <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        ovf_pend <= (32'(bin_in) > MAXV);
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= sh_work;
                    cnt              <= cnt - CNT_W'(1);
                end
                DONE: begin
                    bcd_out   <= ovf_pend ? '1 : scratch;
                    ovf       <= ovf_pend;
                    bcd_valid <= 1'b1;
                end
                default: begin
                    bcd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=10, DIGITS=3).
// Expected BCD comes from a decimal-division reference model.
`timescale 1ns/1ps

module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic [9:0]  bin_in;
    logic        bin_valid;
    logic        bin_ready;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .ovf       (ovf)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish within 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] ref_bcd(input int v);
        if (v > 999) return 12'hFFF;
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic ref_ovf(input int v);
        return (v > 999);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Convert one value: wait for ready, accept, scramble bin_in, then measure
    // latency to the bcd_valid pulse and check the published result.
    task automatic applyStimulus(input int v, input string tag);
        int guard;
        int lat;
        guard = 0;
        while (bin_ready !== 1'b1 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({tag, "/ready"}, 32'(bin_ready), 32'd1);
        bin_in    = 10'(v);
        bin_valid = 1'b1;
        @(posedge clk); #1;
        bin_valid = 1'b0;
        bin_in    = ~10'(v);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bcd_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "/latency"}, 32'(lat), 32'd11);
        checkOutput({tag, "/bcd"}, 32'(bcd_out), 32'(ref_bcd(v)));
        checkOutput({tag, "/ovf"}, 32'(ovf), 32'(ref_ovf(v)));
    endtask

    // Directed sequence.
    initial begin
        int seen;
        rst_n     = 1'b1;
        bin_in    = '0;
        bin_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset/bcd_out", 32'(bcd_out), 32'h0);
        checkOutput("reset/bcd_valid", 32'(bcd_valid), 32'h0);
        checkOutput("reset/ovf", 32'(ovf), 32'h0);
        checkOutput("reset/ready", 32'(bin_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] basic conversions");
        applyStimulus(0, "zero");
        applyStimulus(999, "v999");
        applyStimulus(255, "v255");
        applyStimulus(10, "v10");

        $display("[TB] overflow handling");
        applyStimulus(1000, "v1000");
        applyStimulus(1023, "v1023");
        applyStimulus(7, "v7");
        @(posedge clk); #1;
        checkOutput("pulse/one_cycle", 32'(bcd_valid), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("hold/bcd_out", 32'(bcd_out), 32'h007);
        checkOutput("hold/ovf", 32'(ovf), 32'h0);

        $display("[TB] bin_valid held high, bin_in changing");
        bin_valid = 1'b1;
        for (int c = 0; c < 36; c++) begin
            bin_in = 10'((c * 73 + 3) % 1000);
            @(posedge clk); #1;
            checkOutput("stream/ready", 32'(bin_ready), (c % 12 == 11) ? 32'd1 : 32'd0);
            checkOutput("stream/valid", 32'(bcd_valid), (c % 12 == 11) ? 32'd1 : 32'd0);
            if (c % 12 == 11) begin
                checkOutput("stream/bcd", 32'(bcd_out),
                            32'(ref_bcd(((c - 11) * 73 + 3) % 1000)));
            end
        end
        bin_valid = 1'b0;

        $display("[TB] reset mid-conversion");
        applyStimulus(999, "pre_abort");
        bin_in    = 10'd512;
        bin_valid = 1'b1;
        @(posedge clk); #1;
        bin_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort/bcd_out", 32'(bcd_out), 32'h0);
        checkOutput("abort/ovf", 32'(ovf), 32'h0);
        checkOutput("abort/bcd_valid", 32'(bcd_valid), 32'h0);
        checkOutput("abort/ready", 32'(bin_ready), 32'h1);
        seen = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bcd_valid === 1'b1) seen++;
        end
        checkOutput("abort/no_pulse", 32'(seen), 32'd0);
        applyStimulus(512, "v512");

        $display("[TB] exhaustive sweep");
        for (int v = 0; v < 1024; v++) begin
            applyStimulus(v, "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
